// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling, start-bit qualification and framing-error flag
module uart_rx #(
  parameter int clk_freq   = 25_000_000,
  parameter int baudrate   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = clk_freq / (baudrate * OVERSAMPLE);
  localparam int DW  = $clog2(DIV);
  localparam int TW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_n;
  logic          rx_m, rx_s;
  logic [DW-1:0] div, div_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    sh, sh_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n;
  logic          tick;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div       <= DIV_LAST;
      tcnt      <= '0;
      bcnt      <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= div_n;
      tcnt      <= tcnt_n;
      bcnt      <= bcnt_n;
      sh        <= sh_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  assign tick = (div == '0);
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    div_n   = div;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    sh_n    = sh;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;

    // Holding the divider in IDLE phase-aligns ticks to the detected start edge.
    if (state == IDLE || tick) div_n = DIV_LAST;
    else                       div_n = div - 1'b1;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          tcnt_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt == T_MID) begin
            if (!rx_s) begin
              tcnt_n  = '0;
              bcnt_n  = '0;
              state_n = DATA;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt == T_LAST) begin
            sh_n   = {rx_s, sh[7:1]};
            tcnt_n = '0;
            bcnt_n = bcnt + 1'b1;
            if (bcnt == 3'd7) state_n = STOP;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tcnt == T_LAST) begin
            tcnt_n = '0;
            if (rx_s) begin
              data_n  = sh;
              valid_n = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BREAK;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
